// File: rtl/led_pulse_if.sv
// Event strobes from the core into the LED stretcher and the LED/status
// signals coming back out of it.
interface led_pulse_if #(
    parameter int N = 8
);
    logic [N-1:0] event_in;
    logic         retrig_en;
    logic         drop_clr;
    logic [N-1:0] led_out;
    logic [N-1:0] drop_flag;
    logic         busy;

    modport master (
        output event_in, retrig_en, drop_clr,
        input  led_out, drop_flag, busy
    );

    modport slave (
        input  event_in, retrig_en, drop_clr,
        output led_out, drop_flag, busy
    );
endinterface

// File: rtl/led_pulse_stretch.sv
// Stretches single-cycle core events into human-visible LED flashes with a
// guaranteed off-gap, one queued event per channel and sticky drop flags.
module led_pulse_stretch #(
    parameter int N          = 8,
    parameter int PRESCALE   = 100000,
    parameter int HOLD_TICKS = 100,
    parameter int GAP_TICKS  = 50
) (
    input  logic      clk,
    input  logic      rst,
    led_pulse_if.slave bus
);

    localparam int MAX_TICKS = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
    localparam int CW        = $clog2(MAX_TICKS + 1);
    localparam int PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [CW-1:0] HOLD_L   = CW'(HOLD_TICKS);
    localparam logic [CW-1:0] GAP_L    = CW'(GAP_TICKS);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    logic [PW-1:0]         pre_cnt;
    logic                  tick;

    state_t [N-1:0]        state_q, state_d;
    logic [N-1:0][CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]          pend_q, pend_d;
    logic [N-1:0]          drop_set;
    logic [N-1:0]          drop_q, drop_d;
    logic [N-1:0]          led_q, led_d;
    logic                  busy_q, busy_d;
    logic [N-1:0]          ev;

    assign ev   = bus.event_in;
    assign tick = (pre_cnt == PRE_LAST);

    // Shared time base: one tick every PRESCALE cycles, restarted by reset.
    always_ff @(posedge clk) begin
        if (rst || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        drop_set = '0;
        for (int i = 0; i < N; i++) begin
            case (state_q[i])
                IDLE: begin
                    if (ev[i] || pend_q[i]) begin
                        state_d[i] = HOLD;
                        cnt_d[i]   = HOLD_L;
                        pend_d[i]  = 1'b0;
                    end
                end
                HOLD: begin
                    // A retrigger reload wins over an exit tick in the same cycle.
                    if (ev[i] && bus.retrig_en) begin
                        cnt_d[i] = HOLD_L;
                    end else begin
                        if (ev[i]) begin
                            if (pend_q[i]) drop_set[i] = 1'b1;
                            else           pend_d[i]   = 1'b1;
                        end
                        if (tick) begin
                            if (cnt_q[i] > ONE) begin
                                cnt_d[i] = cnt_q[i] - ONE;
                            end else if (GAP_TICKS > 0) begin
                                state_d[i] = GAP;
                                cnt_d[i]   = GAP_L;
                            end else begin
                                state_d[i] = IDLE;
                            end
                        end
                    end
                end
                GAP: begin
                    // At gap exit a same-cycle event is served directly, never dropped.
                    if (tick && cnt_q[i] <= ONE) begin
                        if (pend_q[i] || ev[i]) begin
                            state_d[i] = HOLD;
                            cnt_d[i]   = HOLD_L;
                            pend_d[i]  = 1'b0;
                        end else begin
                            state_d[i] = IDLE;
                        end
                    end else begin
                        if (ev[i]) begin
                            if (pend_q[i]) drop_set[i] = 1'b1;
                            else           pend_d[i]   = 1'b1;
                        end
                        if (tick) begin
                            cnt_d[i] = cnt_q[i] - ONE;
                        end
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    pend_d[i]  = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        busy_d = 1'b0;
        led_d  = '0;
        for (int i = 0; i < N; i++) begin
            led_d[i] = (state_d[i] == HOLD);
            busy_d   = busy_d | (state_d[i] != IDLE) | pend_d[i];
        end
        // Set beats clear when a drop and drop_clr coincide.
        drop_d = drop_set | (drop_q & ~{N{bus.drop_clr}});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= IDLE;
            end
            cnt_q  <= '0;
            pend_q <= '0;
            drop_q <= '0;
            led_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.led_out   = led_q;
    assign bus.drop_flag = drop_q;
    assign bus.busy      = busy_q;

endmodule
